// File: rtl/pia_bus_sequencer.sv
// pia_bus_sequencer
// Bus master that owns every register access to one MC6820 PIA. After reset
// it writes a fixed six-step init sequence (DDRs and control registers), then
// serves single-byte host reads/writes over a req/ack handshake.
//
// Optional feature macro: PIA_IRQ_SERVICE_EN
//   When defined, IDLE arbitration serves irqa_n, then irqb_n, then req. An
//   IRQ service is a port read (ORA or ORB) reported on irq_valid/irq_port/
//   irq_data instead of ack. When undefined, the IRQ inputs are ignored and
//   the irq_* outputs stay 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, req_rw,        host request (req_rw 1=read), register select and
//   req_rs, req_wdata   write data; sampled only in IDLE
//   ack, rdata          one-cycle completion pulse; read data, held until
//                       the next read completes
//   busy, init_done     state != IDLE; init sequence finished
//   pia_cs, pia_rs,     PIA chip selects, register select, rw (1=read),
//   pia_rw, pia_enable, E strobe, write data and read data
//   pia_di, pia_do
//   irqa_n, irqb_n      PIA interrupt requests, active low
//   irq_valid,          IRQ service complete pulse, port (0=A, 1=B) and
//   irq_port, irq_data  the port data read
//
// Handshake: the host raises req with stable fields and holds them until it
// sees ack. A request is only looked at in IDLE; if req is still high in the
// IDLE cycle after ack, a second access starts.
//
// All outputs are registered: each output flop is loaded from the value it
// must have in the state being entered (state_d).
module pia_bus_sequencer #(
   parameter int         SETUP_CYC  = 1,
   parameter int         STROBE_CYC = 2,
   parameter logic [2:0] CS_ACTIVE  = 3'b011,
   parameter logic [2:0] CS_IDLE    = 3'b100,
   parameter logic [7:0] INIT_DDRA  = 8'h00,
   parameter logic [7:0] INIT_CRA   = 8'h04,
   parameter logic [7:0] INIT_DDRB  = 8'hFF,
   parameter logic [7:0] INIT_CRB   = 8'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       req_rw,
   input  logic [1:0] req_rs,
   input  logic [7:0] req_wdata,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       init_done,
   output logic [2:0] pia_cs,
   output logic [1:0] pia_rs,
   output logic       pia_rw,
   output logic       pia_enable,
   output logic [7:0] pia_di,
   input  logic [7:0] pia_do,
   input  logic       irqa_n,
   input  logic       irqb_n,
   output logic       irq_valid,
   output logic       irq_port,
   output logic [7:0] irq_data
);

   typedef enum logic [2:0] {
      S_INIT_LOAD,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_ACK,
      S_IDLE
   } state_t;

   localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;           // cycles spent in SETUP or STROBE
   logic [2:0] step_q, step_d;         // init write index 0..5
   logic       irq_kind_q, irq_kind_d; // current access is an IRQ service
   logic       irq_sel_q, irq_sel_d;   // port of the current IRQ service
   logic       init_done_q, init_done_d;
   logic       ack_q, ack_d;
   logic [7:0] rdata_q, rdata_d;
   logic       busy_q, busy_d;
   logic [2:0] pia_cs_q, pia_cs_d;
   logic [1:0] pia_rs_q, pia_rs_d;
   logic       pia_rw_q, pia_rw_d;
   logic       pia_enable_q, pia_enable_d;
   logic [7:0] pia_di_q, pia_di_d;
   logic       irq_valid_q, irq_valid_d;
   logic       irq_port_q, irq_port_d;
   logic [7:0] irq_data_q, irq_data_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      step_d       = step_q;
      irq_kind_d   = irq_kind_q;
      irq_sel_d    = irq_sel_q;
      init_done_d  = init_done_q;
      rdata_d      = rdata_q;
      pia_rs_d     = pia_rs_q;
      pia_rw_d     = pia_rw_q;
      pia_di_d     = pia_di_q;
      irq_port_d   = irq_port_q;
      irq_data_d   = irq_data_q;

      case (state_q)
         S_INIT_LOAD: begin
            // Clear CRx first so the following write lands in the DDR, then
            // restore CRx with bit2 set to select the output register.
            case (step_q)
               3'd0:    begin pia_rs_d = 2'd1; pia_di_d = 8'h00;     end
               3'd1:    begin pia_rs_d = 2'd0; pia_di_d = INIT_DDRA; end
               3'd2:    begin pia_rs_d = 2'd1; pia_di_d = INIT_CRA;  end
               3'd3:    begin pia_rs_d = 2'd3; pia_di_d = 8'h00;     end
               3'd4:    begin pia_rs_d = 2'd2; pia_di_d = INIT_DDRB; end
               default: begin pia_rs_d = 2'd3; pia_di_d = INIT_CRB;  end
            endcase
            pia_rw_d   = 1'b0;
            irq_kind_d = 1'b0;
            cnt_d      = 8'd0;
            state_d    = S_SETUP;
         end
         S_IDLE: begin
`ifdef PIA_IRQ_SERVICE_EN
            if (init_done_q && !irqa_n) begin
               pia_rs_d = 2'd0; pia_rw_d = 1'b1; pia_di_d = 8'h00;
               irq_kind_d = 1'b1; irq_sel_d = 1'b0;
               cnt_d = 8'd0; state_d = S_SETUP;
            end else if (init_done_q && !irqb_n) begin
               pia_rs_d = 2'd2; pia_rw_d = 1'b1; pia_di_d = 8'h00;
               irq_kind_d = 1'b1; irq_sel_d = 1'b1;
               cnt_d = 8'd0; state_d = S_SETUP;
            end else
`endif
            if (req) begin
               pia_rs_d   = req_rs;
               pia_rw_d   = req_rw;
               pia_di_d   = req_rw ? 8'h00 : req_wdata;
               irq_kind_d = 1'b0;
               cnt_d      = 8'd0;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_STROBE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               if (pia_rw_q) begin
                  if (irq_kind_q) irq_data_d = pia_do;
                  else            rdata_d    = pia_do;
               end
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (!init_done_q) begin
               if (step_q == 3'd5) begin
                  init_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = S_INIT_LOAD;
               end
            end else begin
               state_d = S_ACK;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_INIT_LOAD;
      endcase

      // Output values for the state being entered.
      pia_cs_d     = (state_d == S_SETUP || state_d == S_STROBE ||
                      state_d == S_HOLD) ? CS_ACTIVE : CS_IDLE;
      pia_enable_d = (state_d == S_STROBE);
      busy_d       = (state_d != S_IDLE);
      ack_d        = (state_d == S_ACK) && !irq_kind_q;
      irq_valid_d  = (state_d == S_ACK) && irq_kind_q;
      if (state_d == S_ACK && irq_kind_q) irq_port_d = irq_sel_q;
      if (state_d == S_ACK || state_d == S_IDLE) begin
         pia_rw_d = 1'b1;
         pia_di_d = 8'h00;
      end
`ifndef PIA_IRQ_SERVICE_EN
      irq_valid_d = 1'b0;
      irq_port_d  = 1'b0;
      irq_data_d  = 8'h00;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_INIT_LOAD;
         cnt_q        <= 8'd0;
         step_q       <= 3'd0;
         irq_kind_q   <= 1'b0;
         irq_sel_q    <= 1'b0;
         init_done_q  <= 1'b0;
         ack_q        <= 1'b0;
         rdata_q      <= 8'h00;
         busy_q       <= 1'b1;
         pia_cs_q     <= CS_IDLE;
         pia_rs_q     <= 2'd0;
         pia_rw_q     <= 1'b1;
         pia_enable_q <= 1'b0;
         pia_di_q     <= 8'h00;
         irq_valid_q  <= 1'b0;
         irq_port_q   <= 1'b0;
         irq_data_q   <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         step_q       <= step_d;
         irq_kind_q   <= irq_kind_d;
         irq_sel_q    <= irq_sel_d;
         init_done_q  <= init_done_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
         pia_cs_q     <= pia_cs_d;
         pia_rs_q     <= pia_rs_d;
         pia_rw_q     <= pia_rw_d;
         pia_enable_q <= pia_enable_d;
         pia_di_q     <= pia_di_d;
         irq_valid_q  <= irq_valid_d;
         irq_port_q   <= irq_port_d;
         irq_data_q   <= irq_data_d;
      end
   end

`ifndef PIA_IRQ_SERVICE_EN
   logic unused_irq;
   assign unused_irq = irqa_n ^ irqb_n;
`endif

   assign ack        = ack_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;
   assign pia_cs     = pia_cs_q;
   assign pia_rs     = pia_rs_q;
   assign pia_rw     = pia_rw_q;
   assign pia_enable = pia_enable_q;
   assign pia_di     = pia_di_q;
   assign irq_valid  = irq_valid_q;
   assign irq_port   = irq_port_q;
   assign irq_data   = irq_data_q;

endmodule

// File: tb/tb_pia_bus_sequencer.sv
// Bench for pia_bus_sequencer. A pin monitor rebuilds every PIA access
// (fields, setup/strobe/hold lengths, completion pulse) and pops the next
// expected access from exp_q; drivers push accesses in the order the DUT
// must perform them. pia_do carries the read value only while E is high.
module tb_pia_bus_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       req_rw = 1'b0;
   logic [1:0] req_rs = 2'd0;
   logic [7:0] req_wdata = 8'h00;
   logic       irqa_n = 1'b1;
   logic       irqb_n = 1'b1;
   logic [7:0] do_val = 8'h00;
   logic [7:0] pia_do;
   logic       ack, busy, init_done, pia_rw, pia_enable, irq_valid, irq_port;
   logic [7:0] rdata, pia_di, irq_data;
   logic [2:0] pia_cs;
   logic [1:0] pia_rs;

   pia_bus_sequencer dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_rs(req_rs),
      .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
      .init_done(init_done), .pia_cs(pia_cs), .pia_rs(pia_rs),
      .pia_rw(pia_rw), .pia_enable(pia_enable), .pia_di(pia_di),
      .pia_do(pia_do), .irqa_n(irqa_n), .irqb_n(irqb_n),
      .irq_valid(irq_valid), .irq_port(irq_port), .irq_data(irq_data)
   );

   assign pia_do = pia_enable ? do_val : ~do_val;

   // clock / reset sampling
   always #5 clk = ~clk;
   logic rst_eff = 1'b1;
   always @(posedge clk) rst_eff <= reset;

   int n_total = 0;
   int n_bad = 0;
   logic [7:0] last_rdata = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected access: {kind[1:0], rw, rs[1:0], di[7:0]}
   // kind 0=init write, 1=host, 2=IRQ A service, 3=IRQ B service
   logic [12:0] exp_q[$];

   function automatic logic [12:0] pack(input logic [1:0] kind, input logic rw,
                                        input logic [1:0] rs, input logic [7:0] di);
      return {kind, rw, rs, di};
   endfunction

   task automatic push_init();
      exp_q.push_back(pack(2'd0, 1'b0, 2'd1, 8'h00));
      exp_q.push_back(pack(2'd0, 1'b0, 2'd0, 8'h00));
      exp_q.push_back(pack(2'd0, 1'b0, 2'd1, 8'h04));
      exp_q.push_back(pack(2'd0, 1'b0, 2'd3, 8'h00));
      exp_q.push_back(pack(2'd0, 1'b0, 2'd2, 8'hFF));
      exp_q.push_back(pack(2'd0, 1'b0, 2'd3, 8'h04));
   endtask

   // scoreboard / pin monitor
   bit          in_acc = 0;
   bit          cur_ok = 0;
   int          pre_en, en_cnt, post_en, init_cnt = 0;
   logic [12:0] cur;
   logic [1:0]  acc_rs, kind;
   logic        acc_rw;
   logic [7:0]  acc_di;
   logic        prev_busy = 1'b1, prev_rst = 1'b1, exp_init_done = 1'b0;
   logic        exp_ack, exp_irqv;

   always @(negedge clk) begin
      exp_ack = 1'b0;
      exp_irqv = 1'b0;
      if (rst_eff) begin
         in_acc = 0;
         exp_q.delete();
         exp_init_done = 1'b0;
         init_cnt = 0;
         check("rst_cs", pia_cs, 3'b100);
         check("rst_enable", pia_enable, 1'b0);
         check("rst_busy", busy, 1'b1);
      end else begin
         if (prev_rst) push_init();
         if (pia_cs == 3'b011) begin
            if (!in_acc) begin
               in_acc = 1; pre_en = 0; en_cnt = 0; post_en = 0;
               acc_rs = pia_rs; acc_rw = pia_rw; acc_di = pia_di;
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  cur_ok = 1;
                  // host/IRQ accesses are accepted in IDLE; init starts from INIT_LOAD
                  check("accept_cycle_busy", prev_busy, cur[12:11] == 2'd0);
               end else begin
                  cur_ok = 0;
                  check("unexpected_access", pia_cs, 3'b100);
               end
            end else begin
               check("addr_stable", {pia_rs, pia_rw, pia_di}, {acc_rs, acc_rw, acc_di});
            end
            if (pia_enable) en_cnt++;
            else if (en_cnt == 0) pre_en++;
            else post_en++;
            check("busy_active", busy, 1'b1);
         end else begin
            check("cs_idle", pia_cs, 3'b100);
            check("enable_idle", pia_enable, 1'b0);
            if (in_acc) begin
               in_acc = 0;
               check("setup_cycles", pre_en, 1);
               check("strobe_cycles", en_cnt, 2);
               check("hold_cycles", post_en, 1);
               if (cur_ok) begin
                  kind = cur[12:11];
                  check("access_fields", {acc_rw, acc_rs, acc_di}, cur[10:0]);
                  exp_ack = (kind == 2'd1);
                  exp_irqv = kind[1];
                  if (kind != 2'd0) check("busy_ack", busy, 1'b1);
                  if (kind[1]) begin
                     check("irq_port", irq_port, kind[0]);
                     check("irq_data", irq_data, do_val);
                  end
                  if (kind == 2'd0) begin
                     init_cnt++;
                     if (init_cnt == 6) exp_init_done = 1'b1;
                  end
               end
            end
         end
      end
      check("ack", ack, exp_ack);
      check("irq_valid", irq_valid, exp_irqv);
      check("init_done", init_done, exp_init_done);
      prev_busy = busy;
      prev_rst = rst_eff;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack();
      int budget = 0;
      tick();
      while (!ack && budget < 120) begin
         tick();
         budget++;
      end
      check("ack_seen", ack, 1'b1);
   endtask

   task automatic wait_irq();
      int budget = 0;
      tick();
      while (!irq_valid && budget < 120) begin
         tick();
         budget++;
      end
      check("irq_valid_seen", irq_valid, 1'b1);
   endtask

   task automatic host_op(input logic rw, input logic [1:0] rs, input logic [7:0] wd,
                          input logic [7:0] dv, input int reps);
      do_val = dv;
      for (int r = 0; r < reps; r++)
         exp_q.push_back(pack(2'd1, rw, rs, rw ? 8'h00 : wd));
      req = 1'b1; req_rw = rw; req_rs = rs; req_wdata = wd;
      for (int r = 0; r < reps; r++) begin
         wait_ack();
         if (rw) last_rdata = dv;
         check("rdata", rdata, last_rdata);
      end
      req = 1'b0;
   endtask

   task automatic reset_release();
      reset = 1'b0;
      last_rdata = 8'h00;
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1;
      tick();
      check("rst_rdata", rdata, 8'h00);
      check("rst_pia_rw", pia_rw, 1'b1);
      check("rst_irq_data", irq_data, 8'h00);
      tick();
      reset_release();

      // raised while init is still running; served once, after init
      host_op(1'b1, 2'd0, 8'h00, 8'h3C, 1);
      // directed read and write
      host_op(1'b1, 2'd1, 8'h00, 8'hFB, 1);
      host_op(1'b0, 2'd2, 8'h5A, 8'h00, 1);
      // req held through ack: exactly two accesses
      host_op(1'b0, 2'd3, 8'hA5, 8'h00, 2);
      host_op(1'b1, 2'd2, 8'h00, 8'hC3, 2);

      for (int i = 0; i < 24; i++) begin
         host_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2 : 1);
         repeat ($urandom_range(0, 3)) tick();
      end

      // reset in the middle of a strobe
      begin
         int budget = 0;
         do_val = 8'h77;
         exp_q.push_back(pack(2'd1, 1'b1, 2'd3, 8'h00));
         req = 1'b1; req_rw = 1'b1; req_rs = 2'd3;
         tick();
         while (!pia_enable && budget < 50) begin
            tick();
            budget++;
         end
         check("strobe_seen", pia_enable, 1'b1);
         reset = 1'b1;
         req = 1'b0;
         tick();
         check("mid_rst_enable", pia_enable, 1'b0);
         check("mid_rst_cs", pia_cs, 3'b100);
         check("mid_rst_busy", busy, 1'b1);
         check("mid_rst_rdata", rdata, 8'h00);
         tick();
         reset_release();
      end
      host_op(1'b1, 2'd1, 8'h00, 8'h96, 1);

      // interrupt inputs asserted together with a host request
`ifdef PIA_IRQ_SERVICE_EN
      do_val = 8'h02;
      exp_q.push_back(pack(2'd2, 1'b1, 2'd0, 8'h00));
      exp_q.push_back(pack(2'd3, 1'b1, 2'd2, 8'h00));
      exp_q.push_back(pack(2'd1, 1'b1, 2'd1, 8'h00));
      irqa_n = 1'b0; irqb_n = 1'b0;
      req = 1'b1; req_rw = 1'b1; req_rs = 2'd1;
      wait_irq();
      check("irqa_port", irq_port, 1'b0);
      check("irqa_data", irq_data, 8'h02);
      check("irq_rdata_untouched", rdata, last_rdata);
      irqa_n = 1'b1;
      wait_irq();
      check("irqb_port", irq_port, 1'b1);
      irqb_n = 1'b1;
      wait_ack();
      last_rdata = 8'h02;
      check("rdata_after_irq", rdata, last_rdata);
      req = 1'b0;
`else
      do_val = 8'h02;
      exp_q.push_back(pack(2'd1, 1'b1, 2'd1, 8'h00));
      irqa_n = 1'b0; irqb_n = 1'b0;
      req = 1'b1; req_rw = 1'b1; req_rs = 2'd1;
      wait_ack();
      last_rdata = 8'h02;
      check("rdata_irq_ignored", rdata, last_rdata);
      check("irq_port_zero", irq_port, 1'b0);
      check("irq_data_zero", irq_data, 8'h00);
      req = 1'b0;
      irqa_n = 1'b1; irqb_n = 1'b1;
`endif

      repeat (4) tick();
      check("queue_drained", exp_q.size(), 0);
      check("final_idle", busy, 1'b0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
